// File: rtl/scr1_dmi_pkg.sv
// Shared types and constants for the DMI scan-chain controller.
package scr1_dmi_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP
   } dmi_fsm_e;

   localparam logic [1:0] DMI_OP_NOP   = 2'd0;
   localparam logic [1:0] DMI_OP_READ  = 2'd1;
   localparam logic [1:0] DMI_OP_WRITE = 2'd2;
   localparam logic [1:0] DMI_OP_RSV   = 2'd3;

   localparam logic [1:0] DMI_ST_OK   = 2'd0;
   localparam logic [1:0] DMI_ST_BUSY = 2'd3;

   localparam int DTMCS_W         = 32;
   localparam int DTMCS_VER_LSB   = 0;
   localparam int DTMCS_ABITS_LSB = 4;
   localparam int DTMCS_STAT_LSB  = 10;
   localparam int DTMCS_IDLE_LSB  = 12;
   localparam int DTMCS_DMIRESET  = 16;
   localparam int DTMCS_HARDRESET = 17;

   localparam int DMI_CH_W = 41;

   function automatic logic [DTMCS_W-1:0] dtmcs_word(
      input logic [3:0] ver,
      input logic [5:0] abits,
      input logic [1:0] stat,
      input logic [2:0] idle
   );
      logic [DTMCS_W-1:0] w;
      w = '0;
      w[DTMCS_VER_LSB   +: 4] = ver;
      w[DTMCS_ABITS_LSB +: 6] = abits;
      w[DTMCS_STAT_LSB  +: 2] = stat;
      w[DTMCS_IDLE_LSB  +: 3] = idle;
      return w;
   endfunction

endpackage

// File: rtl/scr1_dmi_shreg.sv
// Capture/shift register; serial input lands at the top of the
// full DMI chain or at the top of the 32-bit DTMCS window.
module scr1_dmi_shreg
   import scr1_dmi_pkg::*;
#(
   parameter int W = DMI_CH_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         capture,
   input  logic         shift,
   input  logic         ins_hi,
   input  logic         tdi,
   input  logic [W-1:0] cap_data,
   output logic [W-1:0] sr
);

   logic [W-1:0] sr_sh;

   always_comb begin
      sr_sh = sr >> 1;
      if (ins_hi) begin
         sr_sh[W-1] = tdi;
      end else begin
         sr_sh[DTMCS_W-1] = tdi;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr <= '0;
      end else if (capture) begin
         sr <= cap_data;
      end else if (shift) begin
         sr <= sr_sh;
      end
   end

endmodule

// File: rtl/scr1_dmi_chain_ctrl.sv
// SysCLK-side DTMCS/DMI chain controller: turns DMI chain updates
// into single request/response transactions towards the Debug Module.
module scr1_dmi_chain_ctrl
   import scr1_dmi_pkg::*;
#(
   parameter int DMI_AW        = 7,
   parameter int DMI_DW        = 32,
   parameter int DTM_VERSION   = 1,
   parameter int DTM_IDLE_HINT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ch_sel,
   input  logic              ch_id,
   input  logic              ch_capture,
   input  logic              ch_shift,
   input  logic              ch_update,
   input  logic              ch_tdi,
   output logic              ch_tdo,
   output logic              dmi_req,
   output logic              dmi_wr,
   output logic [DMI_AW-1:0] dmi_addr,
   output logic [DMI_DW-1:0] dmi_wdata,
   input  logic              dmi_ack,
   input  logic              dmi_resp,
   input  logic [DMI_DW-1:0] dmi_rdata,
   output logic              dmi_busy_o
);

   localparam int CH_W = DMI_AW + DMI_DW + 2;

   dmi_fsm_e          state;
   logic [CH_W-1:0]   sr;
   logic [CH_W-1:0]   cap_data;
   logic [DMI_AW-1:0] last_addr;
   logic [DMI_DW-1:0] last_rdata;
   logic [1:0]        sticky;

   logic              cap;
   logic              shf;
   logic              upd;
   logic              busy;
   logic [1:0]        op;
   logic [DMI_AW-1:0] up_addr;
   logic [DMI_DW-1:0] up_data;
   logic              dupd;
   logic              hrst;
   logic              sclr;

   // Strobe priority: capture > shift > update.
   assign cap  = ch_sel & ch_capture;
   assign shf  = ch_sel & ~ch_capture & ch_shift;
   assign upd  = ch_sel & ~ch_capture & ~ch_shift & ch_update;

   assign busy       = (state != IDLE);
   assign dmi_busy_o = busy;
   assign ch_tdo     = sr[0];

   assign op      = sr[1:0];
   assign up_data = sr[DMI_DW+1:2];
   assign up_addr = sr[CH_W-1:DMI_DW+2];

   assign dupd = upd & ch_id &
                 ((op == DMI_OP_READ) | (op == DMI_OP_WRITE));
   assign hrst = upd & ~ch_id & sr[DTMCS_HARDRESET];
   assign sclr = upd & ~ch_id & sr[DTMCS_DMIRESET];

   always_comb begin
      cap_data = '0;
      if (ch_id) begin
         cap_data = {last_addr, last_rdata,
                     busy ? DMI_ST_BUSY : sticky};
      end else begin
         cap_data[DTMCS_W-1:0] = dtmcs_word(4'(DTM_VERSION),
                                            6'(DMI_AW), sticky,
                                            3'(DTM_IDLE_HINT));
      end
   end

   scr1_dmi_shreg #(
      .W (CH_W)
   ) i_shreg (
      .clk      (clk),
      .rst      (rst),
      .capture  (cap),
      .shift    (shf),
      .ins_hi   (ch_id),
      .tdi      (ch_tdi),
      .cap_data (cap_data),
      .sr       (sr)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky <= DMI_ST_OK;
      end else if (hrst | sclr) begin
         sticky <= DMI_ST_OK;
      end else if (busy & ((cap & ch_id) | dupd)) begin
         sticky <= DMI_ST_BUSY;
      end
   end

   // A hard reset abandons the transaction; late responses then
   // arrive in IDLE and are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         dmi_req    <= 1'b0;
         dmi_wr     <= 1'b0;
         dmi_addr   <= '0;
         dmi_wdata  <= '0;
         last_addr  <= '0;
         last_rdata <= '0;
      end else if (hrst) begin
         state   <= IDLE;
         dmi_req <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (dupd && sticky == DMI_ST_OK) begin
                  state     <= REQ;
                  dmi_req   <= 1'b1;
                  dmi_wr    <= (op == DMI_OP_WRITE);
                  dmi_addr  <= up_addr;
                  dmi_wdata <= up_data;
                  last_addr <= up_addr;
               end
            end
            REQ: begin
               if (dmi_ack) begin
                  dmi_req <= 1'b0;
                  state   <= dmi_resp ? IDLE : RESP;
                  if (dmi_resp && !dmi_wr) begin
                     last_rdata <= dmi_rdata;
                  end
               end
            end
            RESP: begin
               if (dmi_resp) begin
                  state <= IDLE;
                  if (!dmi_wr) begin
                     last_rdata <= dmi_rdata;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_scr1_dmi_chain_ctrl.sv
// Self-checking bench for scr1_dmi_chain_ctrl against a
// transaction-level model of the DTM chain rules.
module tb_scr1_dmi_chain_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        ch_sel, ch_id, ch_capture, ch_shift, ch_update;
   logic        ch_tdi, ch_tdo;
   logic        dmi_req, dmi_wr;
   logic [6:0]  dmi_addr;
   logic [31:0] dmi_wdata;
   logic        dmi_ack, dmi_resp;
   logic [31:0] dmi_rdata;
   logic        dmi_busy_o;

   int checks   = 0;
   int failures = 0;

   // Model state
   bit          m_busy;
   bit          m_wr;
   logic [1:0]  m_sticky;
   logic [6:0]  m_last_addr;
   logic [31:0] m_last_rdata;

   always #5 clk = ~clk;

   scr1_dmi_chain_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .ch_sel     (ch_sel),
      .ch_id      (ch_id),
      .ch_capture (ch_capture),
      .ch_shift   (ch_shift),
      .ch_update  (ch_update),
      .ch_tdi     (ch_tdi),
      .ch_tdo     (ch_tdo),
      .dmi_req    (dmi_req),
      .dmi_wr     (dmi_wr),
      .dmi_addr   (dmi_addr),
      .dmi_wdata  (dmi_wdata),
      .dmi_ack    (dmi_ack),
      .dmi_resp   (dmi_resp),
      .dmi_rdata  (dmi_rdata),
      .dmi_busy_o (dmi_busy_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- model ----------------
   task automatic m_reset();
      m_busy = 0; m_wr = 0; m_sticky = 0;
      m_last_addr = 0; m_last_rdata = 0;
   endtask

   task automatic m_cap_dmi(output logic [40:0] w);
      w = {m_last_addr, m_last_rdata, m_busy ? 2'd3 : m_sticky};
      if (m_busy) m_sticky = 2'd3;
   endtask

   task automatic m_cap_dtm(output logic [31:0] w);
      w = (32'd1 << 12) | (32'(m_sticky) << 10) | (32'd7 << 4) | 32'd1;
   endtask

   task automatic m_upd_dmi(input logic [6:0] a, input logic [1:0] op,
                            output bit started);
      started = 0;
      if (op == 2'd1 || op == 2'd2) begin
         if (m_busy) m_sticky = 2'd3;
         else if (m_sticky == 2'd0) begin
            started = 1; m_busy = 1;
            m_wr = (op == 2'd2); m_last_addr = a;
         end
      end
   endtask

   task automatic m_upd_dtm(input logic [31:0] w);
      if (w[17]) begin m_busy = 0; m_sticky = 0; end
      else if (w[16]) m_sticky = 0;
   endtask

   task automatic m_resp(input logic [31:0] rd);
      if (m_busy) begin
         if (!m_wr) m_last_rdata = rd;
         m_busy = 0;
      end
   endtask

   // ---------------- stimulus ----------------
   task automatic scan_dmi(input logic [40:0] win, output logic [40:0] wout);
      ch_id = 1; ch_capture = 1; tick(); ch_capture = 0;
      for (int i = 0; i < 41; i++) begin
         wout[i] = ch_tdo; ch_tdi = win[i]; ch_shift = 1; tick();
      end
      ch_shift = 0; ch_update = 1; tick(); ch_update = 0;
   endtask

   task automatic scan_dtm(input logic [31:0] win, output logic [31:0] wout);
      ch_id = 0; ch_capture = 1; tick(); ch_capture = 0;
      for (int i = 0; i < 32; i++) begin
         wout[i] = ch_tdo; ch_tdi = win[i]; ch_shift = 1; tick();
      end
      ch_shift = 0; ch_update = 1; tick(); ch_update = 0;
   endtask

   task automatic dm_pulse(input bit ack, input bit resp, input logic [31:0] rd);
      dmi_ack = ack; dmi_resp = resp; dmi_rdata = rd;
      tick();
      dmi_ack = 0; dmi_resp = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      checks++;
      if ({dmi_req, dmi_wr, dmi_addr, dmi_wdata, ch_tdo, dmi_busy_o} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0",
                  {dmi_req, dmi_wr, dmi_addr, dmi_wdata, ch_tdo, dmi_busy_o});
      end
   endtask

   task automatic test_dtmcs_read();
      logic [31:0] got, exp;
      m_cap_dtm(exp);
      scan_dtm(32'h0, got);
      checks++;
      if (got !== exp || got !== 32'h0000_1071) begin
         failures++;
         $display("FAIL dtmcs_read got=%h exp=%h", got, exp);
      end
   endtask

   task automatic test_strobe_qual();
      ch_id = 0; ch_capture = 1; tick(); ch_capture = 0;
      ch_shift = 1; tick(); ch_shift = 0;
      checks++;
      if (ch_tdo !== 1'b0) begin
         failures++; $display("FAIL shift_one got=%b exp=0", ch_tdo);
      end
      ch_sel = 0; ch_capture = 1; tick(); ch_capture = 0; ch_sel = 1;
      checks++;
      if (ch_tdo !== 1'b0) begin
         failures++; $display("FAIL sel_gate got=%b exp=0", ch_tdo);
      end
      ch_capture = 1; ch_shift = 1; tick(); ch_capture = 0; ch_shift = 0;
      checks++;
      if (ch_tdo !== 1'b1) begin
         failures++; $display("FAIL cap_prio got=%b exp=1", ch_tdo);
      end
   endtask

   task automatic test_dmi_write();
      logic [40:0] got, exp;
      bit st;
      m_cap_dmi(exp);
      scan_dmi({7'h10, 32'h1, 2'd2}, got);
      m_upd_dmi(7'h10, 2'd2, st);
      checks++;
      if ({dmi_req, dmi_wr, dmi_addr, dmi_wdata} !== {1'b1, 1'b1, 7'h10, 32'h1}) begin
         failures++;
         $display("FAIL wr_req got=%h exp=%h",
                  {dmi_req, dmi_wr, dmi_addr, dmi_wdata}, {1'b1, 1'b1, 7'h10, 32'h1});
      end
      dm_pulse(1, 1, 32'hCAFE_F00D);
      m_resp(32'hCAFE_F00D);
      checks++;
      if ({dmi_req, dmi_busy_o} !== 2'b00) begin
         failures++; $display("FAIL wr_done got=%b exp=00", {dmi_req, dmi_busy_o});
      end
      m_cap_dmi(exp);
      scan_dmi(41'h0, got);
      checks++;
      if (got !== exp || got[40:34] !== 7'h10 || got[1:0] !== 2'd0) begin
         failures++; $display("FAIL wr_capture got=%h exp=%h", got, exp);
      end
   endtask

   task automatic test_dmi_read();
      logic [40:0] got, exp;
      bit st;
      scan_dmi({7'h11, 32'h0, 2'd1}, got);
      m_upd_dmi(7'h11, 2'd1, st);
      checks++;
      if ({dmi_req, dmi_wr, dmi_addr} !== {1'b1, 1'b0, 7'h11}) begin
         failures++;
         $display("FAIL rd_req got=%h exp=%h", {dmi_req, dmi_wr, dmi_addr}, {1'b1, 1'b0, 7'h11});
      end
      dm_pulse(1, 0, 32'h0);
      tick(); tick();
      dm_pulse(0, 1, 32'hDEAD_BEEF);
      m_resp(32'hDEAD_BEEF);
      m_cap_dmi(exp);
      scan_dmi(41'h0, got);
      checks++;
      if (got !== exp || got[33:2] !== 32'hDEAD_BEEF) begin
         failures++; $display("FAIL rd_capture got=%h exp=%h", got, exp);
      end
   endtask

   task automatic test_busy();
      logic [40:0] got, exp;
      logic [31:0] dgot, dexp;
      bit st;
      m_cap_dmi(exp);
      scan_dmi({7'h22, 32'h0, 2'd1}, got);
      m_upd_dmi(7'h22, 2'd1, st);
      dm_pulse(1, 0, 32'h0);
      m_cap_dmi(exp);
      scan_dmi({7'h33, 32'h0, 2'd1}, got);
      m_upd_dmi(7'h33, 2'd1, st);
      checks++;
      if (got !== exp || got[1:0] !== 2'd3) begin
         failures++; $display("FAIL busy_capture got=%h exp=%h", got, exp);
      end
      dm_pulse(0, 1, 32'h1234_5678);
      m_resp(32'h1234_5678);
      tick();
      checks++;
      if ({dmi_req, dmi_busy_o} !== 2'b00) begin
         failures++; $display("FAIL busy_no_req got=%b exp=00", {dmi_req, dmi_busy_o});
      end
      m_cap_dtm(dexp);
      scan_dtm(32'h0, dgot);
      checks++;
      if (dgot !== dexp || dgot[11:10] !== 2'd3) begin
         failures++; $display("FAIL sticky_stat got=%h exp=%h", dgot, dexp);
      end
      m_cap_dmi(exp);
      scan_dmi({7'h44, 32'h0, 2'd1}, got);
      m_upd_dmi(7'h44, 2'd1, st);
      checks++;
      if (got !== exp || dmi_req !== 1'b0) begin
         failures++;
         $display("FAIL sticky_drop got=%h/%b exp=%h/0", got, dmi_req, exp);
      end
      m_cap_dtm(dexp);
      scan_dtm(32'h0001_0000, dgot);
      m_upd_dtm(32'h0001_0000);
      m_cap_dtm(dexp);
      scan_dtm(32'h0, dgot);
      checks++;
      if (dgot !== dexp || dgot[11:10] !== 2'd0) begin
         failures++; $display("FAIL sticky_clr got=%h exp=%h", dgot, dexp);
      end
      scan_dmi({7'h44, 32'h0, 2'd1}, got);
      m_upd_dmi(7'h44, 2'd1, st);
      checks++;
      if ({dmi_req, dmi_addr} !== {1'b1, 7'h44}) begin
         failures++; $display("FAIL after_clr got=%h exp=%h", {dmi_req, dmi_addr}, {1'b1, 7'h44});
      end
      dm_pulse(1, 1, 32'h0BAD_0044);
      m_resp(32'h0BAD_0044);
   endtask

   task automatic test_hard_reset();
      logic [40:0] got, exp;
      logic [31:0] dgot, dexp;
      bit st;
      scan_dmi({7'h55, 32'h0, 2'd1}, got);
      m_upd_dmi(7'h55, 2'd1, st);
      m_cap_dtm(dexp);
      scan_dtm(32'h0002_0000, dgot);
      m_upd_dtm(32'h0002_0000);
      checks++;
      if (dgot !== dexp) begin
         failures++; $display("FAIL hr_capture got=%h exp=%h", dgot, dexp);
      end
      checks++;
      if ({dmi_req, dmi_busy_o} !== 2'b00) begin
         failures++; $display("FAIL hr_drop got=%b exp=00", {dmi_req, dmi_busy_o});
      end
      dm_pulse(1, 1, 32'h5555_AAAA);
      m_cap_dmi(exp);
      scan_dmi(41'h0, got);
      checks++;
      if (got !== exp) begin
         failures++; $display("FAIL hr_stray got=%h exp=%h", got, exp);
      end
   endtask

   task automatic test_random();
      logic [40:0] got, exp;
      logic [6:0]  a;
      logic [31:0] d, rd;
      logic [1:0]  op;
      bit st;
      for (int i = 0; i < 25; i++) begin
         a = 7'($urandom); d = $urandom; op = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) dm_pulse(0, 1, $urandom);
         m_cap_dmi(exp);
         scan_dmi({a, d, op}, got);
         m_upd_dmi(a, op, st);
         checks++;
         if (got !== exp) begin
            failures++; $display("FAIL rnd_cap[%0d] got=%h exp=%h", i, got, exp);
         end
         if (st) begin
            checks++;
            if ({dmi_req, dmi_wr, dmi_addr, dmi_wdata} !== {1'b1, op == 2'd2, a, d}) begin
               failures++;
               $display("FAIL rnd_req[%0d] got=%h exp=%h", i,
                        {dmi_req, dmi_wr, dmi_addr, dmi_wdata}, {1'b1, op == 2'd2, a, d});
            end
            repeat ($urandom_range(0, 3)) tick();
            rd = $urandom;
            if ($urandom_range(0, 1) == 1) begin
               dm_pulse(1, 1, rd);
            end else begin
               dm_pulse(1, 0, 32'h0);
               repeat ($urandom_range(0, 3)) tick();
               dm_pulse(0, 1, rd);
            end
            m_resp(rd);
         end
         checks++;
         if ({dmi_req, dmi_busy_o} !== 2'b00) begin
            failures++; $display("FAIL rnd_idle[%0d] got=%b exp=00", i, {dmi_req, dmi_busy_o});
         end
      end
   endtask

   task automatic test_reset_mid_req();
      logic [40:0] got;
      logic [31:0] dgot, dexp;
      bit st;
      scan_dmi({7'h12, 32'h0, 2'd1}, got);
      m_upd_dmi(7'h12, 2'd1, st);
      rst = 1;
      #1;
      checks++;
      if ({dmi_req, ch_tdo, dmi_busy_o} !== 3'b000) begin
         failures++;
         $display("FAIL rst_mid_req got=%b exp=000", {dmi_req, ch_tdo, dmi_busy_o});
      end
      #2 rst = 0;
      m_reset();
      tick();
      m_cap_dtm(dexp);
      scan_dtm(32'h0, dgot);
      checks++;
      if (dgot !== dexp || dgot[11:10] !== 2'd0) begin
         failures++; $display("FAIL rst_dtmcs got=%h exp=%h", dgot, dexp);
      end
   endtask

   initial begin
      rst = 1; ch_sel = 1; ch_id = 0;
      ch_capture = 0; ch_shift = 0; ch_update = 0; ch_tdi = 0;
      dmi_ack = 0; dmi_resp = 0; dmi_rdata = 0;
      m_reset();
      tick(); tick();
      test_reset();
      #2 rst = 0;
      tick();
      test_dtmcs_read();
      test_strobe_qual();
      test_dmi_write();
      test_dmi_read();
      test_busy();
      test_hard_reset();
      test_random();
      test_reset_mid_req();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
